// File: rtl/mdu_sequencer_pkg.sv
// Shared op codes, default latencies, FSM state type and op-class helpers for the MD unit.
// Optional accumulate ops are enabled with `define MDU_MADD_EN.
package mdu_sequencer_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;

  function automatic logic md_is_mul(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Any code not recognised here (including disabled accumulates) behaves as MD_NONE.
  function automatic logic md_is_active(input logic [3:0] op);
    return md_is_mul(op) || md_is_div(op) || (op == MD_MTHI) || (op == MD_MTLO) ||
           (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational MD datapath: produces the 64-bit {hi,lo} result for a launch op.
// Accumulate variants exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        acc;
  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;
  logic               rt_zero;
  logic               div_ovf;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s  = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u  = {32'd0, rs} * {32'd0, rt};
  assign acc     = {hi, lo};
  assign rs_s    = rs;
  assign rt_s    = rt;
  assign rt_zero = (rt == 32'd0);
  assign div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

  always_comb begin
    quo_s = 32'd0;
    rem_s = 32'd0;
    if (!rt_zero && !div_ovf) begin
      quo_s = rs_s / rt_s;
      rem_s = rs_s % rt_s;
    end
  end

  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        if (rt_zero)      result = {rs, 32'hFFFF_FFFF};
        else if (div_ovf) result = {32'd0, 32'h8000_0000};
        else              result = {rem_s, quo_s};
      end
      MD_DIVU: begin
        if (rt_zero) result = {rs, 32'hFFFF_FFFF};
        else         result = {rs % rt, rs / rt};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
      MD_MSUB:  result = acc - prod_s;
      MD_MSUBU: result = acc - prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

  // Only consumed by the accumulate ops.
  logic unused_acc;
  assign unused_acc = ^acc;

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, the latency counter and the stall request.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  md_op,
  input  logic        md_kill,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [63:0]       pending_reg;
  logic [31:0]       hi_reg, lo_reg;
  logic [63:0]       arith_result;
  logic              commit;
  logic              idle_ok;

  mdu_arith u_arith (
    .op     (md_op),
    .rs     (rs_e),
    .rt     (rt_e),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .result (arith_result)
  );

  assign idle_ok  = (state_reg == ST_IDLE) && !md_kill;
  assign md_start = idle_ok && (md_is_mul(md_op) || md_is_div(md_op));
  assign commit   = (state_reg == ST_BUSY) && (cnt_reg == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (md_start) begin
          state_next = ST_BUSY;
          cnt_next   = md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      ST_BUSY: begin
        if (commit) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Result is fixed at launch; HI/LO only change on commit or an idle move-to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= 64'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else begin
      if (md_start)
        pending_reg <= arith_result;
      if (commit) begin
        hi_reg <= pending_reg[63:32];
        lo_reg <= pending_reg[31:0];
      end else if (idle_ok && (md_op == MD_MTHI)) begin
        hi_reg <= rs_e;
      end else if (idle_ok && (md_op == MD_MTLO)) begin
        lo_reg <= rs_e;
      end
    end
  end

  assign md_busy  = (state_reg == ST_BUSY);
  assign md_stall = md_is_active(md_op) && (md_start || md_busy);
  assign hi       = hi_reg;
  assign lo       = lo_reg;

  always_comb begin
    md_rdata = 32'd0;
    if (md_op == MD_MFHI)      md_rdata = hi_reg;
    else if (md_op == MD_MFLO) md_rdata = lo_reg;
  end

  start_while_busy: assert property (@(posedge clk) disable iff (!reset_n) !(md_start && md_busy));

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed-vector bench for mdu_sequencer with hand-computed expected HI/LO and latency values.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [3:0]  md_op;
  logic        md_kill;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        md_start;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  int vectors;
  int miscompares;

  mdu_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_op    (md_op),
    .md_kill  (md_kill),
    .rs_e     (rs_e),
    .rt_e     (rt_e),
    .md_start (md_start),
    .md_busy  (md_busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic kill);
    md_op   = op;
    rs_e    = a;
    rt_e    = b;
    md_kill = kill;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Called just after the start edge; returns at the first negedge with md_busy low.
  task automatic wait_commit(input string tag, input logic hold, output int n);
    bit done;
    n    = 0;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!md_busy) begin
        done = 1;
        break;
      end
      n++;
      if (hold && n == 1) chk({tag, "_stall_held"}, 64'(md_stall), 64'd1);
    end
    if (!done) chk({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  // Launch an op at the current time (just after a posedge), check it starts, then wait.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] hold_op, input int cycles);
    int n;
    drive(op, a, b, 1'b0);
    @(negedge clk);
    chk({tag, "_start"}, 64'(md_start), 64'd1);
    chk({tag, "_stall_on_start"}, 64'(md_stall), 64'd1);
    next_edge();
    drive(hold_op, 32'd5, 32'd0, 1'b0);
    wait_commit(tag, hold_op != MD_NONE, n);
    chk({tag, "_latency"}, 64'(n), 64'(cycles));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(md_busy), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_start", 64'(md_start), 64'd0);
    reset_n = 1'b1;
    next_edge();

    // multu with a held MFLO behind it
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, MD_MFLO, 5);
    chk("multu_stall_clear", 64'(md_stall), 64'd0);
    chk("multu_mflo", 64'(md_rdata), 64'hFFFF_FFFE);
    chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    next_edge();

    run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, MD_NONE, 5);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    next_edge();

    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, MD_MFHI, 10);
    chk("div_mfhi", 64'(md_rdata), 64'hFFFF_FFFF);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    next_edge();

    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, MD_NONE, 10);
    chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    next_edge();

    // divu by zero, with MTHI waiting behind it
    run_op("divu0", MD_DIVU, 32'd1234, 32'd0, MD_MTHI, 10);
    chk("divu0_hilo", {hi, lo}, {32'd1234, 32'hFFFF_FFFF});
    next_edge();
    chk("mthi_after_stall", 64'(hi), 64'd5);
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("mfhi_idle", 64'(md_rdata), 64'd5);
    chk("mfhi_idle_stall", 64'(md_stall), 64'd0);
    next_edge();

    // killed ops do nothing
    drive(MD_MULT, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    chk("kill_start", 64'(md_start), 64'd0);
    chk("kill_stall", 64'(md_stall), 64'd0);
    next_edge();
    chk("kill_busy", 64'(md_busy), 64'd0);
    chk("kill_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    drive(MD_MTLO, 32'h0000_00AA, 32'd0, 1'b1);
    next_edge();
    chk("kill_mtlo", 64'(lo), 64'hFFFF_FFFF);
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    next_edge();

    // reset mid-divide: immediate idle, cleared HI/LO, no later commit
    drive(MD_DIV, 32'd100, 32'd7, 1'b0);
    next_edge();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    repeat (3) next_edge();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(md_busy), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_no_commit_busy", 64'(md_busy), 64'd0);
    chk("rst_no_commit_hilo", {hi, lo}, 64'd0);
    next_edge();

    // accumulate: hi=0, lo=FFFF_FFFF, then maddu 1*1
    drive(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    next_edge();
    chk("madd_setup", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", MD_MADDU, 32'd1, 32'd1, MD_NONE, 5);
    chk("maddu_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
`else
    drive(MD_MADDU, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    chk("maddu_off_start", 64'(md_start), 64'd0);
    chk("maddu_off_stall", 64'(md_stall), 64'd0);
    next_edge();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("maddu_off_busy", 64'(md_busy), 64'd0);
    chk("maddu_off_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
